// File: rtl/plot_scheduler_if.sv
// plot_scheduler_if: requester bundle (req, origin, colour, mask -> gnt, done, busy) plus VGA pixel port (x, y, colour, plot)
interface plot_scheduler_if #(
  parameter int X_W = 8,
  parameter int Y_W = 7
);
  logic [1:0] req;
  logic [2*X_W-1:0] req_x;
  logic [2*Y_W-1:0] req_y;
  logic [5:0] req_colour;
  logic [127:0] req_mask;
  logic [1:0] gnt;
  logic [1:0] done;
  logic busy;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [2:0] colour;
  logic plot;
  modport master (
    output req, req_x, req_y, req_colour, req_mask,
    input gnt, done, busy, x, y, colour, plot
  );
  modport slave (
    input req, req_x, req_y, req_colour, req_mask,
    output gnt, done, busy, x, y, colour, plot
  );
endinterface

// File: rtl/plot_scheduler.sv
// plot_scheduler: round-robin 2-requester 8x8 sprite painter onto the VGA write port; ports clk, rst, bus (slave: req/req_x/req_y/req_colour/req_mask in, gnt/done/busy/x/y/colour/plot out)
module plot_scheduler #(
  parameter int X_W = 8,
  parameter int Y_W = 7
) (
  input logic clk,
  input logic rst,
  plot_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAW, FIN} state_t;
  state_t state_q, state_d;
  logic [5:0] pos_q, pos_d;
  logic g_q, g_d, last_q, last_d, win;
  logic [X_W-1:0] x0_q, x0_d, x_q, x_d;
  logic [Y_W-1:0] y0_q, y0_d, y_q, y_d;
  logic [2:0] fg_q, fg_d, colour_q, colour_d;
  logic [63:0] mask_q, mask_d;
  logic [1:0] gnt_q, gnt_d, done_q, done_d;
  logic busy_q, busy_d, plot_q, plot_d;
  always_comb begin
    win = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    state_d = state_q;
    pos_d = pos_q;
    g_d = g_q;
    last_d = last_q;
    x0_d = x0_q;
    y0_d = y0_q;
    fg_d = fg_q;
    mask_d = mask_q;
    x_d = x_q;
    y_d = y_q;
    colour_d = colour_q;
    gnt_d = gnt_q;
    done_d = 2'b00;
    plot_d = 1'b0;
    unique case (state_q)
      IDLE: if (bus.req != 2'b00) begin
        state_d = DRAW;
        g_d = win;
        pos_d = 6'd0;
        x0_d = win ? bus.req_x[X_W +: X_W] : bus.req_x[0 +: X_W];
        y0_d = win ? bus.req_y[Y_W +: Y_W] : bus.req_y[0 +: Y_W];
        fg_d = win ? bus.req_colour[5:3] : bus.req_colour[2:0];
        mask_d = win ? bus.req_mask[127:64] : bus.req_mask[63:0];
        gnt_d = win ? 2'b10 : 2'b01;
      end
      DRAW: begin
        x_d = x0_q + X_W'(pos_q[5:3]);
        y_d = y0_q + Y_W'(pos_q[2:0]);
        colour_d = mask_q[pos_q] ? fg_q : 3'b000;
        plot_d = 1'b1;
        pos_d = pos_q + 6'd1;
        state_d = (pos_q == 6'd63) ? FIN : DRAW;
      end
      FIN: begin
        state_d = IDLE;
        done_d = gnt_q;
        gnt_d = 2'b00;
        last_d = g_q;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q <= 6'd0;
      g_q <= 1'b0;
      last_q <= 1'b1;
      x0_q <= '0;
      y0_q <= '0;
      fg_q <= 3'b000;
      mask_q <= 64'd0;
      x_q <= '0;
      y_q <= '0;
      colour_q <= 3'b000;
      gnt_q <= 2'b00;
      done_q <= 2'b00;
      busy_q <= 1'b0;
      plot_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q <= pos_d;
      g_q <= g_d;
      last_q <= last_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      fg_q <= fg_d;
      mask_q <= mask_d;
      x_q <= x_d;
      y_q <= y_d;
      colour_q <= colour_d;
      gnt_q <= gnt_d;
      done_q <= done_d;
      busy_q <= busy_d;
      plot_q <= plot_d;
    end
  end
  assign bus.gnt = gnt_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.x = x_q;
  assign bus.y = y_q;
  assign bus.colour = colour_q;
  assign bus.plot = plot_q;
endmodule

// File: tb/tb_plot_scheduler.sv
// tb_plot_scheduler: schedule-based reference model plus directed and random stimulus for plot_scheduler
module tb_plot_scheduler;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  plot_scheduler_if #(.X_W(X_W), .Y_W(Y_W)) bus ();
  plot_scheduler #(.X_W(X_W), .Y_W(Y_W)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [1:0] gnt;
    logic [1:0] done;
    logic busy;
    logic plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    int p;
  } frame_t;
  frame_t q[$];
  frame_t cur;
  int grants[$];
  int errors = 0;
  int checks = 0;
  int last = 1;
  int gap = 0;
  int max_gap = 0;
  bit seen_plot = 0;
  logic [7:0] mx[64], dx[64];
  logic [6:0] my[64], dy[64];
  logic [2:0] mc[64], dc[64];
  function automatic frame_t mk(logic [1:0] g, logic [1:0] d, logic b, logic pl,
                                logic [7:0] xx, logic [6:0] yy, logic [2:0] c, int p);
    frame_t f;
    f.gnt = g; f.done = d; f.busy = b; f.plot = pl; f.x = xx; f.y = yy; f.c = c; f.p = p;
    return f;
  endfunction
  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask
  initial begin
    int w, x0, y0, px, py;
    logic [2:0] fg;
    logic [63:0] m;
    cur = mk(0, 0, 0, 0, 0, 0, 0, -1);
    forever begin
      @(posedge clk);
      if (rst) begin
        q.delete();
        last = 1;
        cur = mk(0, 0, 0, 0, 0, 0, 0, -1);
      end else begin
        if (q.size() == 0 && bus.req != 2'b00) begin
          w = (bus.req == 2'b11) ? 1 - last : (bus.req == 2'b10 ? 1 : 0);
          x0 = int'(bus.req_x[w*X_W +: X_W]);
          y0 = int'(bus.req_y[w*Y_W +: Y_W]);
          fg = bus.req_colour[w*3 +: 3];
          m = bus.req_mask[w*64 +: 64];
          q.push_back(mk(2'(1 << w), 0, 1, 0, 0, 0, 0, -1));
          for (int p = 0; p < 64; p++) begin
            px = (x0 + p / 8) % 256;
            py = (y0 + p % 8) % 128;
            mx[p] = px[7:0];
            my[p] = py[6:0];
            mc[p] = m[p] ? fg : 3'b000;
            q.push_back(mk(2'(1 << w), 0, 1, 1, mx[p], my[p], mc[p], p));
          end
          q.push_back(mk(0, 2'(1 << w), 0, 0, 0, 0, 0, -1));
          last = w;
          grants.push_back(w);
        end
        cur = (q.size() != 0) ? q.pop_front() : mk(0, 0, 0, 0, 0, 0, 0, -1);
      end
    end
  end
  initial forever begin
    @(negedge clk);
    chk("gnt", 64'(bus.gnt), 64'(cur.gnt));
    chk("done", 64'(bus.done), 64'(cur.done));
    chk("busy", 64'(bus.busy), 64'(cur.busy));
    chk("plot", 64'(bus.plot), 64'(cur.plot));
    if (cur.plot) begin
      chk("x", 64'(bus.x), 64'(cur.x));
      chk("y", 64'(bus.y), 64'(cur.y));
      chk("colour", 64'(bus.colour), 64'(cur.c));
      dx[cur.p] = bus.x;
      dy[cur.p] = bus.y;
      dc[cur.p] = bus.colour;
    end
    if (bus.plot) begin
      if (seen_plot && gap > max_gap) max_gap = gap;
      gap = 0;
      seen_plot = 1;
    end else gap++;
  end
  task automatic set_req(int i, logic [7:0] xx, logic [6:0] yy, logic [2:0] c, logic [63:0] m);
    bus.req_x[i*X_W +: X_W] = xx;
    bus.req_y[i*Y_W +: Y_W] = yy;
    bus.req_colour[i*3 +: 3] = c;
    bus.req_mask[i*64 +: 64] = m;
  endtask
  task automatic wait_done(int i);
    int n;
    n = 0;
    while (!bus.done[i] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done[i]) chk($sformatf("wait_done%0d_timeout", i), 64'(bus.done[i]), 64'd1);
  endtask
  task automatic wait_pixel(int p);
    int n;
    n = 0;
    while (cur.p != p && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (cur.p != p) chk($sformatf("wait_pixel%0d_timeout", p), 64'(cur.p), 64'(p));
  endtask
  initial begin
    logic [63:0] ma;
    int cnt;
    bus.req = 2'b00;
    bus.req_x = '0;
    bus.req_y = '0;
    bus.req_colour = '0;
    bus.req_mask = '0;
    repeat (3) @(negedge clk);
    chk("rst_x", 64'(bus.x), 0);
    chk("rst_y", 64'(bus.y), 0);
    chk("rst_colour", 64'(bus.colour), 0);
    chk("rst_plot", 64'(bus.plot), 0);
    chk("rst_busy", 64'(bus.busy), 0);
    chk("rst_gnt", 64'(bus.gnt), 0);
    rst = 1'b0;
    @(negedge clk);
    set_req(0, 8'd10, 7'd20, 3'b010, '1);
    bus.req = 2'b01;
    wait_done(0);
    bus.req = 2'b00;
    chk("basic_m_p0_x", 64'(mx[0]), 10);
    chk("basic_m_p0_y", 64'(my[0]), 20);
    chk("basic_m_p0_c", 64'(mc[0]), 2);
    chk("basic_m_p8_x", 64'(mx[8]), 11);
    chk("basic_m_p63_xy", {mx[63], 1'b0, my[63]}, {8'd17, 8'd27});
    chk("basic_d_p0", {dx[0], 1'b0, dy[0], 5'd0, dc[0]}, {8'd10, 8'd20, 8'd2});
    chk("basic_d_p8", {dx[8], 1'b0, dy[8]}, {8'd11, 8'd20});
    chk("basic_d_p63", {dx[63], 1'b0, dy[63]}, {8'd17, 8'd27});
    @(negedge clk);
    chk("basic_busy_after", 64'(bus.busy), 0);
    set_req(1, 8'd0, 7'd0, 3'b100, 64'h200);
    bus.req = 2'b10;
    wait_done(1);
    bus.req = 2'b00;
    chk("mask_m_p9", {mx[9], 1'b0, my[9], 5'd0, mc[9]}, {8'd1, 8'd1, 8'd4});
    chk("mask_d_p9", {dx[9], 1'b0, dy[9], 5'd0, dc[9]}, {8'd1, 8'd1, 8'd4});
    cnt = 0;
    for (int p = 0; p < 64; p++) if (dc[p] != 3'b000) cnt++;
    chk("mask_lit_count", 64'(cnt), 1);
    rst = 1'b1;
    set_req(0, 8'd30, 7'd40, 3'b001, {$urandom, $urandom});
    set_req(1, 8'd60, 7'd70, 3'b101, {$urandom, $urandom});
    bus.req = 2'b11;
    repeat (2) @(negedge clk);
    grants.delete();
    seen_plot = 0;
    max_gap = 0;
    rst = 1'b0;
    wait_done(0);
    wait_done(1);
    wait_done(0);
    bus.req = 2'b00;
    chk("arb_count", 64'(grants.size() >= 3), 1);
    if (grants.size() >= 3) chk("arb_order", {grants[0][7:0], grants[1][7:0], grants[2][7:0]}, 24'h000100);
    chk("arb_gap_le2", 64'(max_gap <= 2), 1);
    @(negedge clk);
    set_req(0, 8'd254, 7'd125, 3'b111, {$urandom, $urandom});
    bus.req = 2'b01;
    wait_done(0);
    bus.req = 2'b00;
    chk("wrap_m_p16_x", 64'(mx[16]), 0);
    chk("wrap_m_p3_y", 64'(my[3]), 0);
    chk("wrap_m_p63", {mx[63], 1'b0, my[63]}, {8'd5, 8'd4});
    chk("wrap_d_p16_x", 64'(dx[16]), 0);
    chk("wrap_d_p3_y", 64'(dy[3]), 0);
    chk("wrap_d_p63", {dx[63], 1'b0, dy[63]}, {8'd5, 8'd4});
    set_req(0, 8'd50, 7'd50, 3'b011, '1);
    bus.req = 2'b01;
    wait_pixel(30);
    rst = 1'b1;
    bus.req = 2'b00;
    @(negedge clk);
    chk("rstmid_plot", 64'(bus.plot), 0);
    chk("rstmid_gnt", 64'(bus.gnt), 0);
    chk("rstmid_done", 64'(bus.done), 0);
    rst = 1'b0;
    set_req(1, 8'd77, 7'd33, 3'b110, '1);
    bus.req = 2'b10;
    wait_pixel(0);
    chk("rstmid_new_p0", {bus.x, 1'b0, bus.y, bus.gnt}, {8'd77, 8'd33, 2'b10});
    wait_done(1);
    bus.req = 2'b00;
    ma = {$urandom, $urandom};
    set_req(0, 8'd5, 7'd6, 3'b011, ma);
    bus.req = 2'b01;
    wait_pixel(10);
    bus.req_x[7:0] = 8'd99;
    bus.req_mask[63:0] = ~ma;
    bus.req = 2'b00;
    wait_done(0);
    chk("late_m_p20_x", 64'(mx[20]), 7);
    chk("late_d_p20_x", 64'(dx[20]), 7);
    chk("late_d_p20_c", 64'(dc[20]), ma[20] ? 64'd3 : 64'd0);
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 699) == 0);
      if ($urandom_range(0, 15) == 0) bus.req[$urandom_range(0, 1)] ^= 1'b1;
      if ($urandom_range(0, 3) == 0)
        set_req($urandom_range(0, 1), 8'($urandom), 7'($urandom), 3'($urandom), {$urandom, $urandom});
    end
    rst = 1'b0;
    bus.req = 2'b00;
    repeat (80) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/plot_scheduler.md
Name: plot_scheduler

Overview:
- Sequences all pixel writes into the single VGA adapter write port (x, y, colour, plot).
- Two requesters share that port:
  - requester 0 is the judgement-glyph painter in the datapath (PERFECT/GOOD/MISS sprite);
  - requester 1 is the note-lane renderer.
- Each request paints one 8x8 sprite:
  - the requester supplies an origin, a foreground colour and a 64-bit mask;
  - the scheduler arbitrates round-robin, scans the sprite one pixel per clock and returns a done pulse.

Parameters:
- X_W, 8, x coordinate width (160-wide screen).
- Y_W, 7, y coordinate width (120-high screen).

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst  input  1  reset; synchronous, active-high.
- req  input  2  per-requester draw request, level; bit i = requester i.
- req_x  input  2*X_W  sprite origin x; requester i at [i*X_W +: X_W].
- req_y  input  2*Y_W  sprite origin y; requester i at [i*Y_W +: Y_W].
- req_colour  input  6  foreground colour, 3 bits per requester; requester i at [i*3 +: 3].
- req_mask  input  128  sprite mask, 64 bits per requester; requester i at [i*64 +: 64].
- gnt  output  2  one-hot, high while requester i owns the port.
- done  output  2  one-cycle pulse when requester i's sprite is complete.
- busy  output  1  high whenever state != IDLE.
- x  output  X_W  pixel x to VGA adapter.
- y  output  Y_W  pixel y to VGA adapter.
- colour  output  3  pixel colour to VGA adapter.
- plot  output  1  pixel write enable to VGA adapter.

Behaviour:
- Reset values (rst high at a clock edge):
  - state = IDLE; gnt = 0; done = 0; busy = 0; plot = 0; x = 0; y = 0; colour = 0;
  - pos = 0; last_grant = 1, so requester 0 wins the first tie.
- Reset mid-draw: abandon the sprite with no done pulse; plot is low in the cycle after the reset edge.
- All outputs are registered.
- FSM states: IDLE, DRAW, FIN.
- IDLE:
  - If req != 0 at an edge, pick the winner:
    - only one request asserted: that requester;
    - both asserted: the requester != last_grant.
  - At the same edge: set gnt[winner]; latch the winner's origin, colour and mask; pos = 0; go to DRAW.
  - Inputs are sampled only at this edge; later changes to coordinates, colour or mask are ignored.
- DRAW, one pixel per clock for pos = 0..63:
  - col = pos[5:3], row = pos[2:0] (column-major, pixel p = 8*col + row).
  - x = x0 + col, wrapping modulo 2^X_W. y = y0 + row, wrapping modulo 2^Y_W. No clipping.
  - colour = mask[pos] ? fg : 3'b000. The background is painted black, which erases the previous glyph.
  - plot = 1.
  - pos increments. After the edge that emits pos = 63, go to FIN.
- FIN (one cycle):
  - plot = 0, done[g] = 1, gnt = 0, last_grant = g; go to IDLE.
- Timing, with req sampled at edge k:
  - pixel p is on the outputs during the cycle after edge k+1+p, so plot is high for exactly 64 consecutive cycles;
  - done pulses in the cycle after edge k+65;
  - earliest next grant is at edge k+66.
- Request protocol:
  - A requester holds req until it sees done, then drops it in the following cycle.
  - If req is still high at the next IDLE sample, it counts as a new request, subject to round-robin.
- Boundary conditions:
  - req dropped during DRAW: the sprite still completes and done still pulses.
  - req raised during DRAW/FIN: waits; the other requester is never preempted.
  - Both requests held continuously: grants alternate 0,1,0,1...
  - Single requester held continuously: re-granted every 66 cycles.
  - plot is never high in IDLE or FIN.

Test Plan:
- Basic draw:
  - Stimulus: after reset, req=01, x0=10, y0=20, colour=010, mask=all ones.
  - Response: 64 plot cycles; pixel 0 at (10,20) colour 010, pixel 8 at (11,20), pixel 63 at (17,27); done=01 one cycle later; gnt=01 throughout; busy low afterwards.
- Mask selectivity:
  - Stimulus: requester 1, x0=0, y0=0, colour=100, mask with only bit 9 set.
  - Response: colour 100 only at (1,1); the other 63 plot cycles carry colour 000.
- Arbitration:
  - Stimulus: req=11 held from reset with distinct origins.
  - Response: grant order 0,1,0; each done pulse coincides with its own gnt ending; no plot gap longer than 2 cycles between sprites.
- Wrap-around:
  - Stimulus: x0=254, y0=125.
  - Response: pixel 16 (col2,row0) at x=0; pixel 3 (col0,row3) at y=0; pixel 63 at (5,4).
- Reset mid-draw:
  - Stimulus: assert rst during pixel 30.
  - Response: plot 0, gnt 0, no done pulse.
  - Follow-up: after rst drops, a new req=10 starts at pixel 0 with requester 1's origin.
- Late input change:
  - Stimulus: change req_mask/req_x of the granted requester during DRAW.
  - Response: output pixels are unchanged (the latched values are used).
